// File: rtl/stream_multiplexer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_multiplexer_pkg
//  Purpose  : Shared mode encodings and the round-robin pointer helper.
//  Revision : 1.0  initial release
// ============================================================================
package stream_multiplexer_pkg;

    localparam logic STREAM_MODE_FIXED = 1'b0;
    localparam logic STREAM_MODE_RR    = 1'b1;

    // Index following idx in a ring of the given size.
    function automatic int rr_next(input int idx, input int channels);
        return (idx == channels - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_multiplexer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin pick: first asserted request found by
//             scanning from ptr upwards and wrapping at CHANNELS-1 back to 0.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    output logic [SEL_W-1:0]    grant,
    output logic                grant_valid
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam logic [SEL_W:0] CHAN_L = (SEL_W + 1)'(CHANNELS);

    // Scan from ptr and take the first requester; earlier hits win.
    always_comb begin
        logic [SEL_W:0] idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (idx >= CHAN_L) begin
                idx = idx - CHAN_L;
            end
            if (!grant_valid && req[idx[SEL_W-1:0]]) begin
                grant_valid = 1'b1;
                grant       = idx[SEL_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_multiplexer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_multiplexer
//  Purpose  : CHANNELS-input valid/ready multiplexer with a registered output
//             stage; fixed-select or round-robin channel choice.
//  Revision : 1.0  initial release
// ============================================================================
module stream_multiplexer
    import stream_multiplexer_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    input  logic                      out_ready,
    output logic                      sel_error
);

    localparam logic [SEL_W:0] CHAN_L = (SEL_W + 1)'(CHANNELS);

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             sel_in_range;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] chan_data [CHANNELS];

    // Unpack the flat data bus into one word per channel.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign sel_in_range = ({1'b0, sel} < CHAN_L);
    assign sel_error    = (mode == STREAM_MODE_FIXED) && !sel_in_range;
    assign space        = !out_valid || out_ready;

    // Grant source follows mode combinationally, so changes apply this cycle.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode == STREAM_MODE_RR) begin
            grant       = arb_grant;
            grant_valid = arb_valid;
        end else begin
            grant       = sel;
            grant_valid = sel_in_range;
        end
    end

    // Ready goes only to the granted channel, and only while there is room.
    always_comb begin
        in_ready = '0;
        if (!reset && grant_valid && space) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign accept = grant_valid && space && in_valid[grant];

    // Output register and round-robin pointer; the pointer only moves on an
    // accepted round-robin beat, so a held beat is never disturbed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= chan_data[grant];
            out_chan  <= grant;
            if (mode == STREAM_MODE_RR) begin
                rr_ptr <= SEL_W'(rr_next(int'(grant), CHANNELS));
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_multiplexer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_multiplexer
//  Purpose  : Directed self-checking bench for stream_multiplexer (4 and 3
//             channel instances).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_multiplexer;

    logic         clk = 1'b0;
    logic         rst;
    logic         mode;
    logic [1:0]   sel;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_data;
    logic [1:0]   out_chan;
    logic         out_ready;
    logic         sel_error;

    logic         rst3;
    logic         mode3;
    logic [1:0]   sel3;
    logic [2:0]   in_valid3;
    logic [95:0]  in_data3;
    logic [2:0]   in_ready3;
    logic         out_valid3;
    logic [31:0]  out_data3;
    logic [1:0]   out_chan3;
    logic         out_ready3;
    logic         sel_error3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_multiplexer #(.WIDTH(32), .CHANNELS(4)) dut4 (
        .clock(clk), .reset(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_chan(out_chan),
        .out_ready(out_ready), .sel_error(sel_error)
    );

    stream_multiplexer #(.WIDTH(32), .CHANNELS(3)) dut3 (
        .clock(clk), .reset(rst3), .mode(mode3), .sel(sel3),
        .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
        .out_valid(out_valid3), .out_data(out_data3), .out_chan(out_chan3),
        .out_ready(out_ready3), .sel_error(sel_error3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rst3 = 1'b1;
        mode = 1'b0; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; out_ready3 = 1'b1;
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = {16'hA5A5, 16'(i)};
        for (int i = 0; i < 3; i++) in_data3[i*32 +: 32] = {16'hC3C3, 16'(i)};
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h chan=%0d expected 0/0/0", out_valid, out_data, out_chan);
        end
        step(); step();
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        rst = 1'b0; rst3 = 1'b0;
        in_valid = 4'b0000;
        #1;
    endtask

    task automatic test_fixed_select();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL fixed_in_ready: got %b expected 0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL fixed_beat: valid=%b data=%h chan=%0d expected 1/a5a50002/2", out_valid, out_data, out_chan);
        end
        in_valid = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL fixed_drain: valid=%b data=%h expected 0/a5a50002", out_valid, out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp = 2'(k % 4);
            checks++;
            if (in_ready !== (4'b0001 << exp)) begin
                errors++;
                $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, in_ready, 4'b0001 << exp);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== exp || out_data !== {16'hA5A5, 14'd0, exp}) begin
                errors++;
                $display("FAIL rr_beat[%0d]: valid=%b chan=%0d data=%h expected chan %0d", k, out_valid, out_chan, out_data, exp);
            end
        end
        in_valid = 4'b0000;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        // rr_ptr is 2 here; a lone ch1 request is granted after the wrap scan.
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first_ready: got %b expected 0010", in_ready);
        end
        step();
        in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin mode = 1'b0; sel = 2'd3; end
            if (k == 2) begin mode = 1'b1; end
            #1;
            checks++;
            if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_chan !== 2'd1 || out_data !== 32'hA5A5_0001) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ready=%b valid=%b chan=%0d data=%h expected 0000/1/1/a5a50001", k, in_ready, out_valid, out_chan, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++;
            $display("FAIL bp_release_ready: got %b expected 0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 32'hA5A5_0002) begin
            errors++;
            $display("FAIL bp_release_beat: valid=%b chan=%0d data=%h expected 1/2/a5a50002", out_valid, out_chan, out_data);
        end
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL bp_next_ptr: in_ready=%b expected 1000", in_ready);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_wrap_scan();
        // rr_ptr is 3; lone ch0 request moves it to 1.
        mode = 1'b1; in_valid = 4'b0001; out_ready = 1'b1;
        step();
        checks++;
        if (out_chan !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_setup: chan=%0d valid=%b expected 0/1", out_chan, out_valid);
        end
        in_valid = 4'b1000;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_ready: got %b expected 1000", in_ready);
        end
        step();
        checks++;
        if (out_chan !== 2'd3 || out_data !== 32'hA5A5_0003) begin
            errors++;
            $display("FAIL wrap_beat: chan=%0d data=%h expected 3/a5a50003", out_chan, out_data);
        end
        in_valid = 4'b1111;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_ptr_zero: in_ready=%b expected 0001", in_ready);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_async_reset();
        mode = 1'b1; in_valid = 4'b0100; out_ready = 1'b0;
        step();
        in_valid = 4'b1111;
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd2) begin
            errors++;
            $display("FAIL areset_setup: valid=%b chan=%0d expected 1/2", out_valid, out_chan);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || out_data !== 32'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL areset_async: valid=%b chan=%0d data=%h ready=%b expected 0/0/0/0000", out_valid, out_chan, out_data, in_ready);
        end
        step();
        rst = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++;
            $display("FAIL areset_ptr: in_ready=%b expected 0001", in_ready);
        end
        step();
        checks++;
        if (out_chan !== 2'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_first: chan=%0d valid=%b expected 0/1", out_chan, out_valid);
        end
        in_valid = 4'b0000;
        step();
    endtask

    task automatic test_sel_error();
        mode3 = 1'b0; sel3 = 2'd1; in_valid3 = 3'b111; out_ready3 = 1'b1;
        #1;
        checks++;
        if (sel_error3 !== 1'b0 || in_ready3 !== 3'b010) begin
            errors++;
            $display("FAIL selerr_ok: err=%b ready=%b expected 0/010", sel_error3, in_ready3);
        end
        step();
        checks++;
        if (out_valid3 !== 1'b1 || out_chan3 !== 2'd1 || out_data3 !== 32'hC3C3_0001) begin
            errors++;
            $display("FAIL selerr_load: valid=%b chan=%0d data=%h expected 1/1/c3c30001", out_valid3, out_chan3, out_data3);
        end
        sel3 = 2'd3;
        #1;
        checks++;
        if (sel_error3 !== 1'b1 || in_ready3 !== 3'b000) begin
            errors++;
            $display("FAIL selerr_flag: err=%b ready=%b expected 1/000", sel_error3, in_ready3);
        end
        step();
        checks++;
        if (out_valid3 !== 1'b0 || out_data3 !== 32'hC3C3_0001) begin
            errors++;
            $display("FAIL selerr_drain: valid=%b data=%h expected 0/c3c30001", out_valid3, out_data3);
        end
        mode3 = 1'b1;
        #1;
        checks++;
        if (sel_error3 !== 1'b0) begin
            errors++;
            $display("FAIL selerr_rr_mode: err=%b expected 0", sel_error3);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_backpressure();
        test_wrap_scan();
        test_async_reset();
        test_sel_error();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
